// File: rtl/sram_rr_arb_if.sv
// Requester and sram-side bundle for sram_rr_arb. The slave modport belongs to the arbiter.
// The master modport belongs to whatever drives the requests and models the sram.
interface sram_rr_arb_if #(
  parameter int NREQ = 4,
  parameter int AW   = 14,
  parameter int DW   = 32
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*AW-1:0]     req_addr;
  logic [NREQ*DW/8-1:0]   req_byte;
  logic [NREQ*DW-1:0]     req_wdata;
  logic [NREQ-1:0]        req_lock;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rvalid;
  logic [DW-1:0]          rdata;
  logic                   mem_cs;
  logic                   mem_we;
  logic [AW-1:0]          mem_addr;
  logic [DW/8-1:0]        mem_byte;
  logic [DW-1:0]          mem_di;
  logic [DW-1:0]          mem_do;
  logic                   mem_busy;

  modport master (
    output req, req_we, req_addr, req_byte, req_wdata, req_lock, mem_do, mem_busy,
    input  gnt, rvalid, rdata, mem_cs, mem_we, mem_addr, mem_byte, mem_di
  );

  modport slave (
    input  req, req_we, req_addr, req_byte, req_wdata, req_lock, mem_do, mem_busy,
    output gnt, rvalid, rdata, mem_cs, mem_we, mem_addr, mem_byte, mem_di
  );
endinterface

// File: rtl/sram_rr_arb.sv
// Round-robin arbiter sharing one single-port sram among NREQ requesters, one access per cycle.
// Define SRAM_ARB_BURST_EN to let a requester holding req_lock keep priority for up to MAXBST grants.
module sram_rr_arb #(
  parameter int NREQ   = 4,
  parameter int AW     = 14,
  parameter int DW     = 32,
  parameter int MAXBST = 8
) (
  input  logic          clk,
  input  logic          rst,
  sram_rr_arb_if.slave  bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = DW / 8;

  typedef enum logic {IDLE, RET} rd_state_t;

  rd_state_t         rd_state, rd_state_nx;
  logic [NREQ-1:0]   rd_own;
  logic [NREQ-1:0]   grant;
  logic [PW-1:0]     ptr, ptr_nx, winner, winner_inc;
  logic              any_req, issue, rd_issue;
  logic [AW-1:0]     sel_addr, hold_addr;
  logic [BW-1:0]     sel_byte, hold_byte;
  logic [DW-1:0]     sel_di, hold_di;

  // First requester at or after ptr, modulo NREQ; the lowest offset is visited last so it wins.
  always_comb begin
    logic [PW:0] sum;
    winner  = '0;
    any_req = 1'b0;
    sum     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      if (bus.req[sum[PW-1:0]]) begin
        winner  = sum[PW-1:0];
        any_req = 1'b1;
      end
    end
  end

  assign winner_inc = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
  assign issue      = !rst && any_req && !bus.mem_busy;
  assign rd_issue   = issue && !bus.req_we[winner];
  assign grant      = issue ? (NREQ'(1) << winner) : '0;
  assign sel_addr   = bus.req_addr[winner*AW +: AW];
  assign sel_byte   = bus.req_byte[winner*BW +: BW];
  assign sel_di     = bus.req_wdata[winner*DW +: DW];

  // The command is presented while busy too; only gnt waits for the sram to accept it.
  assign bus.gnt      = grant;
  assign bus.mem_cs   = !rst && any_req;
  assign bus.mem_we   = !rst && any_req && bus.req_we[winner];
  assign bus.mem_addr = rst ? '0 : (any_req ? sel_addr : hold_addr);
  assign bus.mem_byte = rst ? '0 : (any_req ? sel_byte : hold_byte);
  assign bus.mem_di   = rst ? '0 : (any_req ? sel_di   : hold_di);

`ifdef SRAM_ARB_BURST_EN
  localparam int CW = $clog2(MAXBST + 1);

  logic [CW-1:0] bst_cnt, bst_nx;
  logic [PW-1:0] bst_own;
  logic          bst_keep;

  // A locked winner keeps the pointer on itself until its run of grants reaches MAXBST.
  always_comb begin
    bst_nx   = (bst_own == winner && bst_cnt != '0) ? bst_cnt + 1'b1 : CW'(1);
    bst_keep = bus.req_lock[winner] && (bst_nx != CW'(MAXBST));
    ptr_nx   = bst_keep ? winner : winner_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bst_cnt <= '0;
      bst_own <= '0;
    end else if (issue) begin
      bst_cnt <= bst_keep ? bst_nx : '0;
      bst_own <= winner;
    end
  end
`else
  assign ptr_nx = winner_inc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      hold_addr <= '0;
      hold_byte <= '0;
      hold_di   <= '0;
    end else begin
      if (any_req) begin
        hold_addr <= sel_addr;
        hold_byte <= sel_byte;
        hold_di   <= sel_di;
      end
      if (issue) ptr <= ptr_nx;
    end
  end

  // Read-return pipe: data comes back from the sram one cycle after a read grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= IDLE;
      rd_own   <= '0;
    end else begin
      rd_state <= rd_state_nx;
      if (rd_issue) rd_own <= grant;
    end
  end

  always_comb begin
    rd_state_nx = rd_issue ? RET : IDLE;
  end

  always_comb begin
    bus.rvalid = '0;
    if (rd_state == RET && !rst) bus.rvalid = rd_own;
    bus.rdata  = bus.mem_do;
  end
endmodule

// File: tb/tb_sram_rr_arb.sv
// Directed bench for sram_rr_arb with a behavioural byte-strobed sram behind the arbiter.
module tb_sram_rr_arb;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sram_rr_arb_if #(.NREQ(4), .AW(14), .DW(32)) bus ();

  sram_rr_arb #(.NREQ(4), .AW(14), .DW(32), .MAXBST(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] sram [0:16383];
  logic        pre_en;
  logic [13:0] pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) sram[pre_addr] <= pre_data;
    else if (bus.mem_cs && !bus.mem_busy) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_byte[b]) sram[bus.mem_addr][8*b +: 8] <= bus.mem_di[8*b +: 8];
      end else begin
        bus.mem_do <= sram[bus.mem_addr];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [13:0] a,
                         input logic [3:0] be, input logic [31:0] d, input logic lk);
    bus.req[i]              = 1'b1;
    bus.req_we[i]           = we;
    bus.req_addr[i*14 +: 14] = a;
    bus.req_byte[i*4 +: 4]  = be;
    bus.req_wdata[i*32 +: 32] = d;
    bus.req_lock[i]         = lk;
  endtask

  task automatic clear_all;
    bus.req = '0; bus.req_we = '0; bus.req_lock = '0;
  endtask

  task automatic do_reset;
    clear_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 14'h2A5, 4'hF, 32'hCAFE0000 + i, 1'b0);
    tick(); tick();
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b want 0000", bus.gnt); end
    checks++; if (bus.rvalid !== 4'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0000", bus.rvalid); end
    checks++; if (bus.mem_cs !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_cs_we got %b%b want 00", bus.mem_cs, bus.mem_we); end
    checks++; if (bus.mem_addr !== 14'h0 || bus.mem_byte !== 4'h0 || bus.mem_di !== 32'h0) begin
      errors++; $display("FAIL reset_fields got %h %h %h want 0 0 0", bus.mem_addr, bus.mem_byte, bus.mem_di); end
    tick();
    clear_all();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read;
    preload(14'h0010, 32'hDEADBEEF);
    set_req(2, 1'b0, 14'h0010, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL rd_gnt got %b want 0100", bus.gnt); end
    checks++; if (bus.mem_cs !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 14'h0010) begin
      errors++; $display("FAIL rd_cmd got cs=%b we=%b a=%h want cs=1 we=0 a=0010", bus.mem_cs, bus.mem_we, bus.mem_addr); end
    tick();
    clear_all();
    @(negedge clk);
    checks++; if (bus.rvalid !== 4'b0100) begin errors++; $display("FAIL rd_rvalid got %b want 0100", bus.rvalid); end
    checks++; if (bus.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata got %h want deadbeef", bus.rdata); end
    checks++; if (bus.mem_cs !== 1'b0 || bus.mem_addr !== 14'h0010) begin
      errors++; $display("FAIL rd_idle_hold got cs=%b a=%h want cs=0 a=0010", bus.mem_cs, bus.mem_addr); end
    tick();
    @(negedge clk);
    checks++; if (bus.rvalid !== 4'b0) begin errors++; $display("FAIL rd_pulse got %b want 0000", bus.rvalid); end
    tick();
  endtask

  task automatic test_round_robin;
    logic [3:0] exp;
    for (int i = 0; i < 4; i++) preload(14'h0100 + 14'(i), 32'hA0000000 + i);
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 14'h0100 + 14'(i), 4'hF, 32'h0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      exp = 4'(1 << (c % 4));
      checks++; if (bus.gnt !== exp) begin errors++; $display("FAIL rr_gnt c=%0d got %b want %b", c, bus.gnt, exp); end
      if (c > 0) begin
        exp = 4'(1 << ((c - 1) % 4));
        checks++; if (bus.rvalid !== exp || bus.rdata !== 32'hA0000000 + 32'((c - 1) % 4)) begin
          errors++; $display("FAIL rr_ret c=%0d got %b %h want %b %h", c, bus.rvalid, bus.rdata, exp, 32'hA0000000 + 32'((c - 1) % 4)); end
      end
      tick();
    end
    clear_all();
    @(negedge clk);
    checks++; if (bus.rvalid !== 4'b0001 || bus.rdata !== 32'hA0000000) begin
      errors++; $display("FAIL rr_last got %b %h want 0001 a0000000", bus.rvalid, bus.rdata); end
    tick();
  endtask

  task automatic test_write_read;
    preload(14'h3FFF, 32'hAABBCCDD);
    set_req(0, 1'b1, 14'h3FFF, 4'b0101, 32'h11223344, 1'b0);
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0001 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b we=%b want 0001 we=1", bus.gnt, bus.mem_we); end
    checks++; if (bus.mem_addr !== 14'h3FFF || bus.mem_byte !== 4'b0101 || bus.mem_di !== 32'h11223344) begin
      errors++; $display("FAIL wr_fields got %h %b %h want 3fff 0101 11223344", bus.mem_addr, bus.mem_byte, bus.mem_di); end
    tick();
    clear_all();
    @(negedge clk);
    checks++; if (bus.rvalid !== 4'b0 || bus.mem_cs !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL wr_after got rv=%b cs=%b we=%b want 0000 0 0", bus.rvalid, bus.mem_cs, bus.mem_we); end
    tick();
    set_req(0, 1'b0, 14'h3FFF, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL wr_rd_gnt got %b want 0001", bus.gnt); end
    tick();
    clear_all();
    @(negedge clk);
    checks++; if (bus.rvalid !== 4'b0001 || bus.rdata !== 32'hAA22CC44) begin
      errors++; $display("FAIL wr_rd_data got %b %h want 0001 aa22cc44", bus.rvalid, bus.rdata); end
    tick();
  endtask

  task automatic test_busy;
    preload(14'h0123, 32'h0BADF00D);
    bus.mem_busy = 1'b1;
    set_req(1, 1'b0, 14'h0123, 4'hF, 32'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (bus.gnt !== 4'b0 || bus.mem_cs !== 1'b1 || bus.mem_addr !== 14'h0123) begin
        errors++; $display("FAIL busy_hold c=%0d got gnt=%b cs=%b a=%h want 0000 1 0123", c, bus.gnt, bus.mem_cs, bus.mem_addr); end
      tick();
    end
    bus.mem_busy = 1'b0;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL busy_release got %b want 0010", bus.gnt); end
    tick();
    clear_all();
    @(negedge clk);
    checks++; if (bus.rvalid !== 4'b0010 || bus.rdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL busy_data got %b %h want 0010 0badf00d", bus.rvalid, bus.rdata); end
    tick();
  endtask

  task automatic test_reset_mid;
    set_req(1, 1'b0, 14'h0123, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL rstmid_gnt got %b want 0010", bus.gnt); end
    tick();
    clear_all();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 14'h0100 + 14'(i), 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (bus.rvalid !== 4'b0 || bus.gnt !== 4'b0 || bus.mem_cs !== 1'b0) begin
      errors++; $display("FAIL rstmid_drop got rv=%b gnt=%b cs=%b want 0000 0000 0", bus.rvalid, bus.gnt, bus.mem_cs); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0001 || bus.rvalid !== 4'b0) begin
      errors++; $display("FAIL rstmid_ptr got gnt=%b rv=%b want 0001 0000", bus.gnt, bus.rvalid); end
    tick();
    clear_all();
    @(negedge clk);
    checks++; if (bus.rvalid !== 4'b0001 || bus.rdata !== 32'hA0000000) begin
      errors++; $display("FAIL rstmid_ret got %b %h want 0001 a0000000", bus.rvalid, bus.rdata); end
    tick();
  endtask

  task automatic test_burst;
    logic [3:0] exp;
    do_reset();
    set_req(0, 1'b0, 14'h0100, 4'hF, 32'h0, 1'b1);
    set_req(1, 1'b0, 14'h0101, 4'hF, 32'h0, 1'b0);
    for (int c = 0; c < 10; c++) begin
`ifdef SRAM_ARB_BURST_EN
      exp = (c == 8) ? 4'b0010 : 4'b0001;
`else
      exp = (c % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
      @(negedge clk);
      checks++; if (bus.gnt !== exp) begin errors++; $display("FAIL burst_gnt c=%0d got %b want %b", c, bus.gnt, exp); end
      tick();
    end
    clear_all();
    tick();
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; checks = 0; errors = 0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_byte = '0;
    bus.req_wdata = '0; bus.req_lock = '0; bus.mem_busy = 1'b0;
    #1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_read();
    test_busy();
    test_reset_mid();
    test_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
